// File: rtl/time_set_ctrl.sv
// Alarm-clock time-set front end: debounces the mode/inc/dec buttons and runs the
// hour/minute edit machine that feeds the time keeper (load) and the display (disp/blank).
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       load,
    output logic       editing,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [3:0] blank_mask
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        COMMIT = 2'd3
    } state_e;

    // Button bit order everywhere: [0]=mode, [1]=inc, [2]=dec.
    logic [2:0]    btnRaw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    stable_q;
    logic [2:0]    stablePrev_q;
    logic [DW-1:0] dbCnt_q [3];
    logic [2:0]    press;
    logic          modeEv;
    logic          incEv;
    logic          decEv;

    state_e        state_q, state_d;
    logic [4:0]    editH_q, editH_d;
    logic [5:0]    editM_q, editM_d;
    logic [4:0]    setHour_q, setHour_d;
    logic [5:0]    setMin_q, setMin_d;
    logic [BW-1:0] blinkCnt_q;
    logic          phase_q;
    logic          blinkClr;
    logic [4:0]    hourInc, hourDec;
    logic [5:0]    minInc, minDec;

    assign btnRaw = {btn_dec, btn_inc, btn_mode};

    // The stable level only moves after DEBOUNCE_CYCLES straight cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stablePrev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= btnRaw;
            sync2_q      <= sync1_q;
            stablePrev_q <= stable_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (dbCnt_q[i] == DB_LAST) begin
                    dbCnt_q[i]  <= '0;
                    stable_q[i] <= sync2_q[i];
                end else begin
                    dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press  = stable_q & ~stablePrev_q;
    assign modeEv = press[0];
    assign incEv  = press[1] & ~press[2];
    assign decEv  = press[2] & ~press[1];

    assign hourInc = (editH_q >= 5'd23) ? 5'd0 : editH_q + 5'd1;
    assign hourDec = (editH_q == 5'd0 || editH_q > 5'd23) ? 5'd23 : editH_q - 5'd1;
    assign minInc  = (editM_q >= 6'd59) ? 6'd0 : editM_q + 6'd1;
    assign minDec  = (editM_q == 6'd0 || editM_q > 6'd59) ? 6'd59 : editM_q - 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            editH_q   <= '0;
            editM_q   <= '0;
            setHour_q <= '0;
            setMin_q  <= '0;
        end else begin
            state_q   <= state_d;
            editH_q   <= editH_d;
            editM_q   <= editM_d;
            setHour_q <= setHour_d;
            setMin_q  <= setMin_d;
        end
    end

    // Mode wins over inc/dec in the same cycle; blinkClr restarts the blink on any visible change.
    always_comb begin
        state_d   = state_q;
        editH_d   = editH_q;
        editM_d   = editM_q;
        setHour_d = setHour_q;
        setMin_d  = setMin_q;
        blinkClr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (modeEv) begin
                    editH_d  = cur_hour;
                    editM_d  = cur_min;
                    state_d  = EDIT_H;
                    blinkClr = 1'b1;
                end
            end
            EDIT_H: begin
                if (modeEv) begin
                    state_d  = EDIT_M;
                    blinkClr = 1'b1;
                end else if (incEv) begin
                    editH_d  = hourInc;
                    blinkClr = 1'b1;
                end else if (decEv) begin
                    editH_d  = hourDec;
                    blinkClr = 1'b1;
                end
            end
            EDIT_M: begin
                if (modeEv) begin
                    state_d   = COMMIT;
                    setHour_d = editH_q;
                    setMin_d  = editM_q;
                end else if (incEv) begin
                    editM_d  = minInc;
                    blinkClr = 1'b1;
                end else if (decEv) begin
                    editM_d  = minDec;
                    blinkClr = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign editing = (state_q == EDIT_H) || (state_q == EDIT_M);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blinkCnt_q <= '0;
            phase_q    <= 1'b0;
        end else if (!editing || blinkClr) begin
            blinkCnt_q <= '0;
            phase_q    <= 1'b0;
        end else if (blinkCnt_q == BL_LAST) begin
            blinkCnt_q <= '0;
            phase_q    <= ~phase_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
        end
    end

    assign load      = (state_q == COMMIT);
    assign set_hour  = setHour_q;
    assign set_min   = setMin_q;
    assign disp_hour = editing ? editH_q : cur_hour;
    assign disp_min  = editing ? editM_q : cur_min;

    always_comb begin
        blank_mask = 4'b0000;
        if (phase_q && state_q == EDIT_H) begin
            blank_mask = 4'b1100;
        end else if (phase_q && state_q == EDIT_M) begin
            blank_mask = 4'b0011;
        end
    end

endmodule
